ex10_alu_wb: RTL and testbench
==============================

Name: ex10_alu_wb

Overview:
- Consumer end of the register-read → ALU interface.
- Takes the registered operand bundle (operands, opcode, ROB id, destination) and computes a 32-bit integer result.
- Buffers results in a small FIFO and presents them to the shared writeback bus using a valid/ready handshake.
- Drives a busy signal back to the scheduler so that issued ops are never dropped.

Parameters:
- DEPTH, 4, result FIFO entries; power of two, ≥2.

Ports:
- cpu_clock_i  in  1  core clock
- cpu_reset_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; discards buffered and incoming results
- alu_a  in  32  operand A
- alu_b  in  32  operand B (register or immediate)
- alu_opc  in  4  opcode
- alu_rob_id  in  5  ROB tag
- alu_dest  in  6  physical destination register
- alu_valid  in  1  operand bundle valid this cycle
- alu_busy_o  out  1  scheduler must not issue to this unit next cycle
- wb_valid_o  out  1  writeback entry valid
- wb_data_o  out  32  result
- wb_rob_o  out  5  ROB tag of result
- wb_dest_o  out  6  destination register of result
- wb_ready_i  in  1  writeback bus accepts entry this cycle
- overflow_o  out  1  sticky error: push attempted while full with no pop

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; rd/wr pointers and count = 0.
  - wb_valid_o = 0, alu_busy_o = 0, overflow_o = 0.
  - wb_data_o / wb_rob_o / wb_dest_o = 0.
- Compute (combinational on alu_* inputs):
  - 0 ADD a+b
  - 1 SUB a−b
  - 2 SLL a<<b[4:0]
  - 3 SLT signed a<b → 1/0
  - 4 SLTU unsigned
  - 5 XOR
  - 6 SRL logical
  - 7 SRA arithmetic
  - 8 OR
  - 9 AND
  - 10 PASSB (result = b)
  - 11–15 → result 0
  - All arithmetic modulo 2^32; no exceptions.
- Push: alu_valid=1 and flush_i=0 → {result, rob, dest} written at the clock edge.
  - Latency: alu_valid in cycle N, FIFO empty → wb_valid_o=1 in cycle N+1 with that entry.
  - There is no combinational bypass.
- Pop: wb_valid_o & wb_ready_i → head advances at the edge.
  - wb_* is driven from the head entry (registered storage).
  - Payload holds stable while wb_valid_o=1 and wb_ready_i=0.
- Simultaneous push+pop: count unchanged; allowed even when full.
- Full, push without pop: entry dropped, count unchanged, overflow_o set.
  - overflow_o stays set until reset; flush does not clear it.
- alu_busy_o = (count_next ≥ DEPTH−1), registered. This covers the one op already in flight in the register-read stage.
- Flush:
  - Next cycle count=0 and pointers=0; wb_valid_o=0.
  - A push in the flush cycle is discarded.
  - A pop in the flush cycle is still considered taken by the bus; no effect on state beyond the clear.
  - alu_busy_o deasserts the cycle after.
- Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Results are emitted in order; no reordering by ROB tag.

Decomposition:
- Shared package holds:
  - opcode enum (ALU_ADD … ALU_PASSB)
  - writeback entry struct {data[31:0], rob[4:0], dest[5:0]}
  - width constants ROB_W=5, PREG_W=6, XLEN=32
- Sub-module alu_core: pure combinational opcode/operand → result.
- FIFO, handshake, busy and overflow logic stay in the top module.

Test Plan:
- ADD a=0x7FFFFFFF, b=1, rob=3, dest=12, ready=1 → next cycle wb_valid_o=1, data=0x80000000, rob=3, dest=12; then wb_valid_o=0.
- SRA a=0x80000000, b=0x24; SLT a=0xFFFFFFFF, b=1; SLTU same operands; opc 13 → 0xF8000000, 1, 0, 0 in issue order.
- wb_ready_i=0, four back-to-back valid ops:
  - alu_busy_o rises after the 3rd push (DEPTH=4).
  - Payload stable while stalled.
  - A 5th push → overflow_o=1 and count stays 4.
  - Raising ready drains rob tags 0,1,2,3 in order.
- FIFO full, simultaneous push+pop every cycle → no overflow; count stays 4; ordering preserved.
- Two entries buffered, flush_i with alu_valid=1 → next cycle wb_valid_o=0, count=0; a new push afterwards appears 1 cycle later.
- Reset asserted mid-stream with 3 entries buffered → outputs go to reset values immediately (async), not at the next edge.

Source files
------------

// File: rtl/ex10_alu_wb_pkg.sv
// ex10_alu_wb_pkg: shared widths, opcode encoding and writeback entry type
package ex10_alu_wb_pkg;
  localparam int XLEN   = 32;
  localparam int ROB_W  = 5;
  localparam int PREG_W = 6;
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } opc_e;
  typedef struct packed {
    logic [XLEN-1:0]   data;
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] dest;
  } wb_entry_t;
endpackage

// File: rtl/ex10_alu_wb_alu_core.sv
// ex10_alu_wb_alu_core: combinational integer ALU, unused opcodes yield zero
module ex10_alu_wb_alu_core
  import ex10_alu_wb_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [3:0]      opc_i,
  output logic [XLEN-1:0] res_o
);
  logic [4:0] sh;
  assign sh = b_i[4:0];
  always_comb begin
    case (opc_i)
      ALU_ADD:   res_o = a_i + b_i;
      ALU_SUB:   res_o = a_i - b_i;
      ALU_SLL:   res_o = a_i << sh;
      ALU_SLT:   res_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_SLTU:  res_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      ALU_XOR:   res_o = a_i ^ b_i;
      ALU_SRL:   res_o = a_i >> sh;
      ALU_SRA:   res_o = $unsigned($signed(a_i) >>> sh);
      ALU_OR:    res_o = a_i | b_i;
      ALU_AND:   res_o = a_i & b_i;
      ALU_PASSB: res_o = b_i;
      default:   res_o = '0;
    endcase
  end
endmodule

// File: rtl/ex10_alu_wb.sv
// ex10_alu_wb: ALU result FIFO feeding the writeback bus with busy/overflow back-pressure
module ex10_alu_wb
  import ex10_alu_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              cpu_clock_i,
  input  logic              cpu_reset_ni,
  input  logic              flush_i,
  input  logic [XLEN-1:0]   alu_a,
  input  logic [XLEN-1:0]   alu_b,
  input  logic [3:0]        alu_opc,
  input  logic [ROB_W-1:0]  alu_rob_id,
  input  logic [PREG_W-1:0] alu_dest,
  input  logic              alu_valid,
  output logic              alu_busy_o,
  output logic              wb_valid_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic [ROB_W-1:0]  wb_rob_o,
  output logic [PREG_W-1:0] wb_dest_o,
  input  logic              wb_ready_i,
  output logic              overflow_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [XLEN-1:0] res;
  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, ovf_q, ovf_d;
  logic            push, pop, full, acc;
  ex10_alu_wb_alu_core u_alu (
    .a_i  (alu_a),
    .b_i  (alu_b),
    .opc_i(alu_opc),
    .res_o(res)
  );
  assign push = alu_valid & ~flush_i;
  assign pop  = wb_valid_o & wb_ready_i;
  assign full = cnt_q == CW'(DEPTH);
  // when full, a simultaneous pop frees the very slot the tail points at
  assign acc  = push & (~full | pop);
  always_comb begin
    rd_d  = flush_i ? '0 : rd_q + PW'(pop);
    wr_d  = flush_i ? '0 : wr_q + PW'(acc);
    cnt_d = flush_i ? '0 : cnt_q + CW'(acc) - CW'(pop);
    ovf_d = ovf_q | (push & full & ~pop);
  end
  always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
    if (!cpu_reset_ni) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      busy_q <= cnt_d >= CW'(DEPTH - 1);
      ovf_q  <= ovf_d;
      if (acc) mem_q[wr_q] <= '{data: res, rob: alu_rob_id, dest: alu_dest};
    end
  end
  assign wb_valid_o = cnt_q != '0;
  assign wb_data_o  = mem_q[rd_q].data;
  assign wb_rob_o   = mem_q[rd_q].rob;
  assign wb_dest_o  = mem_q[rd_q].dest;
  assign alu_busy_o = busy_q;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_ex10_alu_wb.sv
// tb_ex10_alu_wb: directed and random checks of ex10_alu_wb against a queue-based model
module tb_ex10_alu_wb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, valid, ready;
  logic [31:0] a, b;
  logic [3:0]  opc;
  logic [4:0]  rob;
  logic [5:0]  dest;
  logic        busy, wb_valid, ovf;
  logic [31:0] wb_data;
  logic [4:0]  wb_rob;
  logic [5:0]  wb_dest;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  r;
    logic [5:0]  t;
  } ent_t;
  ent_t q[$];
  logic m_ovf;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ex10_alu_wb #(.DEPTH(4)) dut (
    .cpu_clock_i (clk),
    .cpu_reset_ni(rst_n),
    .flush_i     (flush),
    .alu_a       (a),
    .alu_b       (b),
    .alu_opc     (opc),
    .alu_rob_id  (rob),
    .alu_dest    (dest),
    .alu_valid   (valid),
    .alu_busy_o  (busy),
    .wb_valid_o  (wb_valid),
    .wb_data_o   (wb_data),
    .wb_rob_o    (wb_rob),
    .wb_dest_o   (wb_dest),
    .wb_ready_i  (ready),
    .overflow_o  (ovf)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int unsigned s;
    s = y % 32;
    case (o)
      4'd0:  return x + y;
      4'd1:  return x + ~y + 32'd1;
      4'd2:  return x << s;
      4'd3:  return ((x[31] != y[31]) ? x[31] : (x < y)) ? 32'd1 : 32'd0;
      4'd4:  return (x < y) ? 32'd1 : 32'd0;
      4'd5:  return x ^ y;
      4'd6:  return x >> s;
      4'd7:  return (x >> s) | (x[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      4'd8:  return x | y;
      4'd9:  return x & y;
      4'd10: return y;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".valid"}, 32'(wb_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk({tag, ".data"}, wb_data, q[0].d);
      chk({tag, ".rob"}, 32'(wb_rob), 32'(q[0].r));
      chk({tag, ".dest"}, 32'(wb_dest), 32'(q[0].t));
    end
    chk({tag, ".busy"}, 32'(busy), 32'(q.size() >= 3));
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
  endtask

  // drive one cycle of inputs, advance the model, then check after the edge
  task automatic step(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [4:0] r, input logic [5:0] t, input logic v, input logic rd, input logic f);
    ent_t e;
    bit   pp;
    int   sz;
    opc = o; a = x; b = y; rob = r; dest = t; valid = v; ready = rd; flush = f;
    sz = q.size();
    pp = (sz != 0) && rd;
    e = '{d: ref_alu(o, x, y), r: r, t: t};
    if (f) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (v && (sz < 4 || pp)) q.push_back(e);
      else if (v) m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    rst_n = 1'b0; flush = 0; valid = 0; ready = 0; a = 0; b = 0; opc = 0; rob = 0; dest = 0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset");
    chk("reset.data", wb_data, 32'd0);
    chk("reset.rob", 32'(wb_rob), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step("add", 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd3, 6'd12, 1, 1, 0);
    chk("add.const", wb_data, 32'h8000_0000);
    step("add.drain", 4'd0, 0, 0, 0, 0, 0, 1, 0);

    step("sra", 4'd7, 32'h8000_0000, 32'h24, 5'd1, 6'd1, 1, 1, 0);
    chk("sra.const", wb_data, 32'hF800_0000);
    step("slt", 4'd3, 32'hFFFF_FFFF, 32'd1, 5'd2, 6'd2, 1, 1, 0);
    chk("slt.const", wb_data, 32'd1);
    step("sltu", 4'd4, 32'hFFFF_FFFF, 32'd1, 5'd3, 6'd3, 1, 1, 0);
    chk("sltu.const", wb_data, 32'd0);
    step("opc13", 4'd13, 32'h1234_5678, 32'h9, 5'd4, 6'd4, 1, 1, 0);
    chk("opc13.const", wb_data, 32'd0);
    step("opc13.drain", 4'd0, 0, 0, 0, 0, 0, 1, 0);

    // full FIFO with push+pop every cycle must not overflow
    for (int i = 0; i < 4; i++) step("fill", 4'd5, $urandom, $urandom, 5'(i), 6'(i), 1, 0, 0);
    for (int i = 4; i < 10; i++) step("pushpop", 4'd8, $urandom, $urandom, 5'(i), 6'(i), 1, 1, 0);
    chk("pushpop.noovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 4; i++) step("drain1", 4'd0, 0, 0, 0, 0, 0, 1, 0);

    // stalled bus: busy after 3rd push, overflow on 5th
    for (int i = 0; i < 4; i++) begin
      step("stall", 4'd0, $urandom, $urandom, 5'(i), 6'(i + 20), 1, 0, 0);
      if (i == 2) chk("stall.busy3", 32'(busy), 32'd1);
    end
    step("overflow", 4'd1, 32'd9, 32'd3, 5'd9, 6'd9, 1, 0, 0);
    chk("overflow.const", 32'(ovf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("drain.order", 32'(wb_rob), i);
      step("drain2", 4'd0, 0, 0, 0, 0, 0, 1, 0);
    end

    // flush with two buffered entries and a concurrent push
    step("fl.a", 4'd2, 32'd1, 32'd4, 5'd5, 6'd5, 1, 0, 0);
    step("fl.b", 4'd6, 32'hF0, 32'd4, 5'd6, 6'd6, 1, 0, 0);
    step("flush", 4'd0, 32'd1, 32'd1, 5'd7, 6'd7, 1, 0, 1);
    chk("flush.valid", 32'(wb_valid), 32'd0);
    step("postflush", 4'd10, 0, 32'hABCD, 5'd8, 6'd8, 1, 0, 0);
    chk("postflush.data", wb_data, 32'h0000_ABCD);
    step("postflush.drain", 4'd0, 0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 300; i++)
      step("rand", 4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom), 6'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
    for (int i = 0; i < 5; i++) step("rdrain", 4'd0, 0, 0, 0, 0, 0, 1, 0);

    // async reset with three buffered entries
    for (int i = 0; i < 3; i++) step("pre_rst", 4'd0, 32'd100, 32'(i), 5'(i + 1), 6'(i + 1), 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(wb_valid), 32'd0);
    chk("arst.data", wb_data, 32'd0);
    chk("arst.rob", 32'(wb_rob), 32'd0);
    chk("arst.dest", 32'(wb_dest), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.ovf", 32'(ovf), 32'd0);
    q.delete();
    m_ovf = 1'b0;
    valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step("after_rst", 4'd0, 32'd5, 32'd6, 5'd1, 6'd2, 1, 1, 0);
    step("after_rst.drain", 4'd0, 0, 0, 0, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
